// File: rtl/systolic_ws_pkg.sv
// Shared definitions for the weight-stationary systolic array blocks
// (array, feeder, psum collector).
//
// Contents:
//   DEFAULT_DATA_WIDTH / DEFAULT_COLS / DEFAULT_DEPTH : shared default sizes
//   psum_w()   : partial-sum width for a given PE operand width (2*DATA_WIDTH)
//   lane_lsb() : LSB position of lane j inside a packed row of psum lanes
package systolic_ws_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_COLS       = 4;
    localparam int DEFAULT_DEPTH      = 8;

    // A product of two DATA_WIDTH operands is 2*DATA_WIDTH wide; psums keep that width.
    function automatic int psum_w(input int data_width);
        return 2 * data_width;
    endfunction

    // Lane j of a packed row occupies bits [j*pw +: pw].
    function automatic int lane_lsb(input int lane, input int pw);
        return lane * pw;
    endfunction

endpackage

// File: rtl/ws_row_fifo.sv
// Show-ahead row FIFO for the psum collector.
//
// The head entry is always presented on rdata (read straight from storage,
// no write-to-read bypass), so a row pushed at an edge is visible on the
// following cycle. Pointers wrap modulo DEPTH; the occupancy counter runs
// 0..DEPTH independently of the pointers.
//
// Ports:
//   clk    in  clock, rising edge
//   rstn   in  synchronous active-low reset
//   clr    in  synchronous flush (same effect as reset)
//   push   in  write wdata at the tail (caller guarantees a free slot or a simultaneous pop)
//   pop    in  retire the head (caller guarantees non-empty)
//   wdata  in  row to write
//   rdata  out current head row (undefined content when empty)
//   full   out count == DEPTH
//   empty  out count == 0
//   count  out rows stored
module ws_row_fifo #(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;

    // Storage carries no reset: an entry is only ever read after it was written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn || clr) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + AW'(1);
            end
            if (pop) begin
                rptr <= rptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign rdata = mem[rptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/ws_psum_collector.sv
// Output collector for the weight-stationary array.
//
// Deskews the bottom-row psum stream (column j arrives j cycles after
// column 0) into whole rows and buffers them in a show-ahead FIFO toward
// the writeback/DMA side. The array cannot be back-pressured, so a row that
// completes while the FIFO is full and not being popped is dropped and the
// sticky o_overflow flag is raised.
//
// Optional build macro: WS_COLLECTOR_RELU_EN -- when defined, every lane is
// clamped to max(psum, 0) as the row is pushed. Latency and handshake are
// the same in both builds.
//
// Handshake (output side): the head row is transferred on every rising edge
// where o_valid & i_ready are both 1; o_data is stable while o_valid=1 and
// i_ready=0, and is forced to 0 whenever o_valid=0.
//
// Ports:
//   clk        in  clock, rising edge
//   rstn       in  synchronous active-low reset
//   i_clr      in  synchronous flush, same effect as reset
//   i_psum     in  COLS lanes of PSUM_W, lane j = [j*PSUM_W +: PSUM_W]
//   i_valid    in  lane 0 of a new row is valid (lane j follows j cycles later)
//   o_data     out FIFO head row, same lane packing
//   o_valid    out head row available
//   i_ready    in  consumer accepts the head
//   o_full     out FIFO holds DEPTH rows
//   o_count    out rows stored
//   o_overflow out sticky: a completed row was dropped
module ws_psum_collector
    import systolic_ws_pkg::*;
#(
    parameter  int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter  int COLS       = DEFAULT_COLS,
    parameter  int DEPTH      = DEFAULT_DEPTH,
    localparam int PSUM_W     = 2 * DATA_WIDTH,
    localparam int ROW_W      = COLS * PSUM_W,
    localparam int CW         = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_clr,
    input  logic [ROW_W-1:0] i_psum,
    input  logic             i_valid,
    output logic [ROW_W-1:0] o_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_full,
    output logic [CW-1:0]    o_count,
    output logic             o_overflow
);

    logic             w_en;      // a whole deskewed row is present this cycle
    logic [ROW_W-1:0] row_data;  // deskewed (and optionally clamped) row
    logic [ROW_W-1:0] head_data;
    logic             fifo_empty;
    logic             fifo_full;
    logic             push;
    logic             pop;

    // Valid pipe: COLS-1 stages so w_en lines up with the last lane.
    generate
        if (COLS > 1) begin : g_vpipe
            logic [COLS-2:0] vpipe;
            always_ff @(posedge clk) begin
                if (!rstn || i_clr) begin
                    vpipe <= '0;
                end else begin
                    vpipe[0] <= i_valid;
                    for (int k = 1; k < COLS - 1; k++) begin
                        vpipe[k] <= vpipe[k-1];
                    end
                end
            end
            assign w_en = vpipe[COLS-2];
        end else begin : g_novpipe
            assign w_en = i_valid;
        end
    endgenerate

    // Deskew: lane j is delayed COLS-1-j cycles so all lanes meet together.
    generate
        for (genvar j = 0; j < COLS; j++) begin : g_lane
            localparam int D = COLS - 1 - j;
            logic [PSUM_W-1:0] lane_q;

            if (D == 0) begin : g_direct
                assign lane_q = i_psum[lane_lsb(j, PSUM_W) +: PSUM_W];
            end else begin : g_delay
                logic [PSUM_W-1:0] dl [D];
                always_ff @(posedge clk) begin
                    dl[0] <= i_psum[lane_lsb(j, PSUM_W) +: PSUM_W];
                    for (int k = 1; k < D; k++) begin
                        dl[k] <= dl[k-1];
                    end
                end
                assign lane_q = dl[D-1];
            end

`ifdef WS_COLLECTOR_RELU_EN
            // Negative psums (MSB set) are stored as zero.
            assign row_data[lane_lsb(j, PSUM_W) +: PSUM_W] =
                lane_q[PSUM_W-1] ? '0 : lane_q;
`else
            assign row_data[lane_lsb(j, PSUM_W) +: PSUM_W] = lane_q;
`endif
        end
    endgenerate

    // A pop in the same cycle frees the slot a full FIFO needs for the push.
    assign pop  = o_valid && i_ready;
    assign push = w_en && (!fifo_full || pop);

    always_ff @(posedge clk) begin
        if (!rstn || i_clr) begin
            o_overflow <= 1'b0;
        end else if (w_en && fifo_full && !pop) begin
            o_overflow <= 1'b1;
        end
    end

    ws_row_fifo #(
        .WIDTH (ROW_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .clr   (i_clr),
        .push  (push),
        .pop   (pop),
        .wdata (row_data),
        .rdata (head_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (o_count)
    );

    assign o_valid = !fifo_empty;
    assign o_full  = fifo_full;
    assign o_data  = o_valid ? head_data : '0;

endmodule

// File: tb/tb_ws_psum_collector.sv
// Bench for ws_psum_collector (COLS=4, DEPTH=4, DATA_WIDTH=8).
// The reference model tracks whole rows: a row launched at cycle c is due
// at cycle c+3, and the expected FIFO is a queue of rows.
module tb_ws_psum_collector;

    localparam int DW    = 8;
    localparam int COLS  = 4;
    localparam int DEPTH = 4;
    localparam int PW    = 2 * DW;
    localparam int RW    = COLS * PW;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          i_clr = 1'b0;
    logic [RW-1:0] i_psum = '0;
    logic          i_valid = 1'b0;
    logic [RW-1:0] o_data;
    logic          o_valid;
    logic          i_ready = 1'b0;
    logic          o_full;
    logic [2:0]    o_count;
    logic          o_overflow;

    ws_psum_collector #(
        .DATA_WIDTH (DW),
        .COLS       (COLS),
        .DEPTH      (DEPTH)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .i_clr      (i_clr),
        .i_psum     (i_psum),
        .i_valid    (i_valid),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_full     (o_full),
        .o_count    (o_count),
        .o_overflow (o_overflow)
    );

    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [RW-1:0] exp_q[$];      // expected FIFO contents, head at [0]
    logic [RW-1:0] infl_row[$];   // rows launched, not yet complete
    int            infl_due[$];   // cycle in which each row completes
    logic          exp_ovf = 1'b0;
    logic [RW-1:0] hist [COLS];   // row presented at cycle c-k
    int            cyc = 0;
    int            n_checks = 0;
    int            n_fail = 0;

    task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [RW-1:0] mk_row(input int k);
        logic [RW-1:0] r;
        for (int j = 0; j < COLS; j++) r[j*PW +: PW] = PW'(k * 16 + j);
        return r;
    endfunction

    function automatic logic [RW-1:0] rnd_row();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [RW-1:0] stored(input logic [RW-1:0] r);
        logic [RW-1:0] s;
        s = r;
`ifdef WS_COLLECTOR_RELU_EN
        for (int j = 0; j < COLS; j++) begin
            if (r[j*PW + PW - 1]) s[j*PW +: PW] = '0;
        end
`endif
        return s;
    endfunction

    task automatic check_outputs();
        int n;
        n = exp_q.size();
        chk("valid", RW'(o_valid), RW'(n != 0));
        chk("data", o_data, (n != 0) ? exp_q[0] : '0);
        chk("count", RW'(o_count), RW'(n));
        chk("full", RW'(o_full), RW'(n == DEPTH));
        chk("overflow", RW'(o_overflow), RW'(exp_ovf));
    endtask

    // One clock cycle: drive skewed lanes, advance the model at the edge, check.
    task automatic step(input logic launch, input logic [RW-1:0] row,
                        input logic rdy, input logic rn, input logic cl);
        logic          pop;
        logic          done;
        logic [RW-1:0] r;
        logic [RW-1:0] p;
        for (int k = COLS - 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = launch ? row : rnd_row();
        for (int j = 0; j < COLS; j++) p[j*PW +: PW] = hist[j][j*PW +: PW];
        i_psum  = p;
        i_valid = launch;
        i_ready = rdy;
        rstn    = rn;
        i_clr   = cl;
        @(posedge clk);
        if (launch) begin
            infl_row.push_back(row);
            infl_due.push_back(cyc + COLS - 1);
        end
        pop  = (exp_q.size() != 0) && rdy;
        done = (infl_due.size() != 0) && (infl_due[0] == cyc);
        r    = '0;
        if (done) begin
            r = infl_row.pop_front();
            void'(infl_due.pop_front());
        end
        if (!rn || cl) begin
            exp_q.delete();
            infl_row.delete();
            infl_due.delete();
            exp_ovf = 1'b0;
        end else begin
            if (pop) void'(exp_q.pop_front());
            if (done) begin
                if (exp_q.size() < DEPTH) exp_q.push_back(stored(r));
                else exp_ovf = 1'b1;
            end
        end
        cyc++;
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b0, '0, rdy, 1'b1, 1'b0);
    endtask

    logic [RW-1:0] r5;

    initial begin
        for (int k = 0; k < COLS; k++) hist[k] = '0;

        // Reset
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk("rst_valid", RW'(o_valid), '0);
        chk("rst_count", RW'(o_count), '0);

        // 1. single row, consumer always ready
        step(1'b1, {16'd40, 16'd30, 16'd20, 16'd10}, 1'b1, 1'b1, 1'b0);
        idle(3, 1'b1);
        chk("s1_valid", RW'(o_valid), RW'(1));
        chk("s1_data", o_data, {16'd40, 16'd30, 16'd20, 16'd10});
        idle(1, 1'b1);
        chk("s1_drain", RW'(o_count), '0);
        idle(2, 1'b1);

        // 2. five back-to-back rows with no consumer: row 4 dropped
        for (int k = 0; k < 5; k++) step(1'b1, mk_row(k), 1'b0, 1'b1, 1'b0);
        idle(4, 1'b0);
        chk("s2_full", RW'(o_full), RW'(1));
        chk("s2_count", RW'(o_count), RW'(4));
        chk("s2_ovf", RW'(o_overflow), RW'(1));
        chk("s2_head", o_data, mk_row(0));
        idle(5, 1'b1);
        chk("s2_ovf_kept", RW'(o_overflow), RW'(1));

        // 3. full FIFO, pop on the cycle a new row completes
        step(1'b0, '0, 1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 4; k++) step(1'b1, mk_row(k + 8), 1'b0, 1'b1, 1'b0);
        idle(4, 1'b0);
        step(1'b1, mk_row(12), 1'b0, 1'b1, 1'b0);
        idle(2, 1'b0);
        step(1'b0, '0, 1'b1, 1'b1, 1'b0);
        chk("s3_count", RW'(o_count), RW'(4));
        chk("s3_ovf", RW'(o_overflow), '0);
        chk("s3_head", o_data, mk_row(9));
        idle(6, 1'b1);

        // 4. reset with 2 rows in FIFO and 2 rows in the deskew pipe
        step(1'b1, mk_row(1), 1'b0, 1'b1, 1'b0);
        step(1'b1, mk_row(2), 1'b0, 1'b1, 1'b0);
        idle(2, 1'b0);
        step(1'b1, mk_row(3), 1'b0, 1'b1, 1'b0);
        step(1'b1, mk_row(4), 1'b0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk("s4_valid", RW'(o_valid), '0);
        chk("s4_data", o_data, '0);
        chk("s4_count", RW'(o_count), '0);
        idle(6, 1'b1);

        // 5. negative lane
        r5 = {16'd3, 16'd3, 16'hFFF6, 16'd3};
        step(1'b1, r5, 1'b0, 1'b1, 1'b0);
        idle(3, 1'b0);
`ifdef WS_COLLECTOR_RELU_EN
        chk("s5_lanes", o_data, {16'd3, 16'd3, 16'h0000, 16'd3});
`else
        chk("s5_lanes", o_data, {16'd3, 16'd3, 16'hFFF6, 16'd3});
`endif
        idle(2, 1'b1);

        // 6. clear with overflow set and 3 rows stored
        for (int k = 0; k < 5; k++) step(1'b1, mk_row(k + 20), 1'b0, 1'b1, 1'b0);
        idle(3, 1'b0);
        step(1'b0, '0, 1'b1, 1'b1, 1'b0);
        chk("s6_pre_count", RW'(o_count), RW'(3));
        chk("s6_pre_ovf", RW'(o_overflow), RW'(1));
        step(1'b0, '0, 1'b0, 1'b1, 1'b1);
        chk("s6_count", RW'(o_count), '0);
        chk("s6_ovf", RW'(o_overflow), '0);
        step(1'b1, mk_row(30), 1'b0, 1'b1, 1'b0);
        idle(3, 1'b0);
        chk("s6_row", o_data, mk_row(30));
        idle(2, 1'b1);

        // Random traffic with occasional flush
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) != 0), rnd_row(), ($urandom_range(0, 2) != 0),
                 1'b1, ($urandom_range(0, 99) == 0));
        end
        idle(8, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
